chan_mux_rr: RTL and testbench



---
 rtl/chan_mux_rr.sv | 99 +++++++++
 tb/tb_chan_mux_rr.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/chan_mux_rr.sv
// Registered N-to-1 word multiplexer with per-channel valid/ready handshakes.
// Selects one channel per cycle, either directly by index or by round-robin scan.
module chan_mux_rr #(
  parameter int CHANNELS = 8,
  parameter int WIDTH    = 8,
  localparam int SELW    = (CHANNELS > 2) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SELW-1:0]           sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SELW-1:0]           out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam logic [SELW:0]   CH_W   = (SELW+1)'(CHANNELS);
  localparam logic [SELW-1:0] LAST_W = SELW'(CHANNELS - 1);

  logic [WIDTH-1:0]    r_data_p1;
  logic [SELW-1:0]     r_chan_p1;
  logic                r_vld_p1;
  logic [SELW-1:0]     r_rr_ptr;

  logic                w_space;
  logic                w_grant;
  logic                w_xfer;
  logic [SELW-1:0]     w_gidx;
  logic [SELW:0]       w_sum;
  logic [CHANNELS-1:0] w_rot;
  logic [WIDTH-1:0]    w_data;

  // Stage p0: grant selection and input handshake
  assign w_space = !r_vld_p1 || out_ready;
  assign w_xfer  = w_space && w_grant && !reset;

  always_comb begin
    w_grant = 1'b0;
    w_gidx  = '0;
    w_sum   = '0;
    // Rotate valids so bit k corresponds to channel rr_ptr+k (mod CHANNELS).
    w_rot   = CHANNELS'({in_valid, in_valid} >> r_rr_ptr);
    if (!mode) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (sel == SELW'(i) && in_valid[i]) begin
          w_grant = 1'b1;
          w_gidx  = SELW'(i);
        end
      end
    end else begin
      // Scan downward so the nearest valid channel after rr_ptr wins last.
      for (int k = CHANNELS - 1; k >= 0; k--) begin
        if (w_rot[k]) begin
          w_sum = {1'b0, r_rr_ptr} + (SELW+1)'(k);
          if (w_sum >= CH_W) w_sum = w_sum - CH_W;
          w_gidx  = w_sum[SELW-1:0];
          w_grant = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_data   = '0;
    in_ready = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_gidx == SELW'(i)) begin
        w_data      = in_data[i*WIDTH +: WIDTH];
        in_ready[i] = w_xfer;
      end
    end
  end

  // Stage p1: output register and round-robin pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_p1  <= 1'b0;
      r_data_p1 <= '0;
      r_chan_p1 <= '0;
      r_rr_ptr  <= '0;
    end else if (w_xfer) begin
      r_vld_p1  <= 1'b1;
      r_data_p1 <= w_data;
      r_chan_p1 <= w_gidx;
      if (mode) r_rr_ptr <= (w_gidx == LAST_W) ? '0 : w_gidx + 1'b1;
    end else if (out_ready) begin
      r_vld_p1  <= 1'b0;
    end
  end

  assign out_data  = r_data_p1;
  assign out_chan  = r_chan_p1;
  assign out_valid = r_vld_p1;

endmodule

// File: tb/tb_chan_mux_rr.sv
// Bench for chan_mux_rr: directed test-plan steps followed by random traffic,
// checked against a behavioural model of the arbitration rules.
module tb_chan_mux_rr;
  localparam int CH  = 8;
  localparam int W   = 8;
  localparam int SW  = 3;
  localparam int CH6 = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic [CH*W-1:0] in_data;
  logic [CH-1:0] in_valid;
  logic [CH-1:0] in_ready;
  logic          mode;
  logic [SW-1:0] sel;
  logic [W-1:0]  out_data;
  logic [SW-1:0] out_chan;
  logic          out_valid;
  logic          out_ready;

  logic [CH6*W-1:0] in_data6;
  logic [CH6-1:0]   in_valid6;
  logic [CH6-1:0]   in_ready6;
  logic [SW-1:0]    out_chan6;
  logic [W-1:0]     out_data6;
  logic             out_valid6;

  int n_cmp = 0;
  int n_err = 0;

  // Model state
  bit        m_vld;
  bit [7:0]  m_data;
  int        m_chan;
  int        m_ptr;

  always #5 clk = ~clk;

  chan_mux_rr #(.CHANNELS(CH), .WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
    .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready)
  );

  chan_mux_rr #(.CHANNELS(CH6), .WIDTH(W)) dut6 (
    .clk(clk), .reset(reset), .in_data(in_data6), .in_valid(in_valid6),
    .in_ready(in_ready6), .mode(1'b0), .sel(3'd7), .out_data(out_data6),
    .out_chan(out_chan6), .out_valid(out_valid6), .out_ready(1'b1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Winning channel under the arbitration rules, or -1 for no grant.
  function automatic int model_grant();
    if (!mode) return (int'(sel) < CH && in_valid[sel]) ? int'(sel) : -1;
    for (int k = 0; k < CH; k++)
      if (in_valid[(m_ptr + k) % CH]) return (m_ptr + k) % CH;
    return -1;
  endfunction

  task automatic set_ch(input int c, input logic [7:0] v);
    in_data[c*W +: W] = v;
  endtask

  task automatic cycle(input string tag);
    int g;
    bit space;
    logic [7:0] exp_rdy;
    #1;
    space   = !m_vld || out_ready;
    g       = reset ? -1 : model_grant();
    exp_rdy = (g >= 0 && space) ? 8'(1 << g) : 8'h00;
    check({tag, ".in_ready"}, 64'(in_ready), 64'(exp_rdy));
    @(posedge clk);
    if (reset) begin
      m_vld = 0; m_data = 0; m_chan = 0; m_ptr = 0;
    end else if (g >= 0 && space) begin
      m_vld  = 1;
      m_data = in_data[g*W +: W];
      m_chan = g;
      if (mode) m_ptr = (g + 1) % CH;
    end else if (out_ready) begin
      m_vld = 0;
    end
    #1;
    check({tag, ".out_valid"}, 64'(out_valid), 64'(m_vld));
    check({tag, ".out_data"},  64'(out_data),  64'(m_data));
    check({tag, ".out_chan"},  64'(out_chan),  64'(m_chan));
  endtask

  int seq[6] = '{0, 4, 7, 0, 4, 7};

  initial begin
    reset = 1; in_data = '0; in_valid = '0; mode = 0; sel = '0; out_ready = 1;
    in_data6 = {6{8'h5A}}; in_valid6 = '1;
    m_vld = 0; m_data = 0; m_chan = 0; m_ptr = 0;
    repeat (2) cycle("reset");
    check("reset.rr_ptr", 64'(dut.r_rr_ptr), 64'd0);
    check("reset.valid", 64'(out_valid), 64'd0);
    reset = 0;

    // Direct select
    for (int i = 0; i < CH; i++) set_ch(i, 8'($urandom));
    set_ch(5, 8'hA5); set_ch(3, 8'h33);
    in_valid = 8'hFF; sel = 3'd5;
    #1 check("dir5.rdy", 64'(in_ready), 64'h20);
    cycle("dir5");
    check("dir5.data", 64'(out_data), 64'hA5);
    check("dir5.chan", 64'(out_chan), 64'd5);
    sel = 3'd3;
    #1 check("dir3.rdy", 64'(in_ready), 64'h08);
    cycle("dir3");
    check("dir3.data", 64'(out_data), 64'h33);

    // Round-robin wrap
    mode = 1; in_valid = 8'h91;
    for (int i = 0; i < 6; i++) begin
      cycle("rr_wrap");
      check("rr_wrap.seq", 64'(out_chan), 64'(seq[i]));
      check("rr_wrap.vld", 64'(out_valid), 64'd1);
      if (i == 0) check("rr_wrap.ptr", 64'(dut.r_rr_ptr), 64'd1);
    end

    // Back-pressure
    mode = 0; sel = 3'd1; in_valid = 8'hFF; set_ch(1, 8'h11);
    cycle("bp_load");
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      set_ch(1, 8'($urandom));
      #1 check("bp.rdy", 64'(in_ready), 64'h0);
      cycle("bp_hold");
      check("bp.data", 64'(out_data), 64'h11);
    end
    out_ready = 1; sel = 3'd2; set_ch(2, 8'h22);
    #1 check("bp_release.rdy", 64'(in_ready), 64'h04);
    cycle("bp_release");
    check("bp_release.data", 64'(out_data), 64'h22);
    check("bp_release.vld", 64'(out_valid), 64'd1);

    // Empty input drains the register
    in_valid = 8'h00;
    cycle("empty");
    check("empty.vld", 64'(out_valid), 64'd0);
    check("empty.data", 64'(out_data), 64'h22);

    // Out-of-range select on a 6-channel instance
    check("sel_oob.rdy", 64'(in_ready6), 64'h0);
    check("sel_oob.vld", 64'(out_valid6), 64'd0);

    // Reset mid-stream: park rr_ptr at 3 first so the restart is visible
    mode = 1; in_valid = 8'h04;
    cycle("pre_rst");
    check("pre_rst.ptr", 64'(dut.r_rr_ptr), 64'd3);
    out_ready = 0; in_valid = 8'hFF;
    cycle("pre_rst_hold");
    reset = 1;
    cycle("mid_rst");
    reset = 0;
    check("mid_rst.vld", 64'(out_valid), 64'd0);
    check("mid_rst.data", 64'(out_data), 64'h0);
    check("mid_rst.chan", 64'(out_chan), 64'd0);
    out_ready = 1; in_valid = 8'h0C;
    cycle("rr_restart");
    check("rr_restart.chan", 64'(out_chan), 64'd2);

    // Mode switch keeps rr_ptr
    mode = 0; sel = 3'd6; in_valid = 8'hFF;
    repeat (2) begin
      cycle("msw_direct");
      check("msw_direct.chan", 64'(out_chan), 64'd6);
    end
    check("msw.ptr", 64'(dut.r_rr_ptr), 64'd3);
    mode = 1;
    cycle("msw_rr");
    check("msw_rr.chan", 64'(out_chan), 64'd3);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      in_data   = {$urandom, $urandom};
      in_valid  = 8'($urandom);
      mode      = 1'($urandom);
      sel       = 3'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 3) != 0);
      reset     = ($urandom_range(0, 49) == 0);
      cycle("random");
    end
    reset = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
